// File: rtl/memory_pt2.sv
// Load-response stage: captures load context, waits for read data,
// aligns/extends it and holds a single write-back across stalls.
module memory_pt2 (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        stall_in,
    input  logic        req_valid,
    input  logic [2:0]  ld_type,
    input  logic [1:0]  ld_offset,
    input  logic [31:0] ld_rt_data,
    input  logic [4:0]  ld_wreg,
    input  logic        data_ok,
    input  logic [31:0] rdata,
    output logic        load_busy,
    output logic        stall_req_mempt2,
    output logic        wb_valid,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic [2:0]  ctx_type;
    logic [1:0]  ctx_off;
    logic [31:0] ctx_rt;
    logic [4:0]  ctx_wreg;

    logic        accept;
    logic        latch;
    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] aligned;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (req_valid && !flush) state_nx = S_WAIT;
            S_WAIT: begin
                if (flush && data_ok) state_nx = S_IDLE;
                else if (flush)       state_nx = S_DROP;
                else if (data_ok)     state_nx = S_DONE;
            end
            S_DONE: begin
                if (flush)                      state_nx = S_IDLE;
                else if (!stall_in && req_valid) state_nx = S_WAIT;
                else if (!stall_in)             state_nx = S_IDLE;
            end
            S_DROP: if (data_ok) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        wb_valid         = (state == S_DONE);
        stall_req_mempt2 = (state == S_WAIT) && !flush;
        load_busy        = (state == S_WAIT) || (state == S_DROP) ||
                           ((state == S_DONE) && stall_in);
        // A new load is taken from IDLE or as the held result drains.
        accept = !flush && req_valid &&
                 ((state == S_IDLE) || ((state == S_DONE) && !stall_in));
        latch  = (state == S_WAIT) && data_ok && !flush;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctx_type <= 3'd0;
            ctx_off  <= 2'd0;
            ctx_rt   <= 32'd0;
            ctx_wreg <= 5'd0;
        end else if (accept) begin
            ctx_type <= ld_type;
            ctx_off  <= ld_offset;
            ctx_rt   <= ld_rt_data;
            ctx_wreg <= ld_wreg;
        end
    end

    always_comb begin
        shifted  = rdata >> {ctx_off, 3'b000};
        byte_sel = shifted[7:0];
        half_sel = ctx_off[1] ? rdata[31:16] : rdata[15:0];
        case (ctx_type)
            3'b000: aligned = {{24{byte_sel[7]}}, byte_sel};
            3'b001: aligned = {24'd0, byte_sel};
            3'b010: aligned = {{16{half_sel[15]}}, half_sel};
            3'b011: aligned = {16'd0, half_sel};
            3'b101: begin
                case (ctx_off)
                    2'd0:    aligned = {rdata[7:0], ctx_rt[23:0]};
                    2'd1:    aligned = {rdata[15:0], ctx_rt[15:0]};
                    2'd2:    aligned = {rdata[23:0], ctx_rt[7:0]};
                    default: aligned = rdata;
                endcase
            end
            3'b110: begin
                case (ctx_off)
                    2'd0:    aligned = rdata;
                    2'd1:    aligned = {ctx_rt[31:24], rdata[31:8]};
                    2'd2:    aligned = {ctx_rt[31:16], rdata[31:16]};
                    default: aligned = {ctx_rt[31:8], rdata[31:24]};
                endcase
            end
            default: aligned = rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_data <= 32'd0;
            wb_reg  <= 5'd0;
        end else if (latch) begin
            wb_data <= aligned;
            wb_reg  <= ctx_wreg;
        end
    end

endmodule

// File: tb/tb_memory_pt2.sv
// Bench for memory_pt2: directed scenarios plus random loads checked
// against a byte-level model of the load alignment rules.
module tb_memory_pt2;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        stall_in;
    logic        req_valid;
    logic [2:0]  ld_type;
    logic [1:0]  ld_offset;
    logic [31:0] ld_rt_data;
    logic [4:0]  ld_wreg;
    logic        data_ok;
    logic [31:0] rdata;
    logic        load_busy;
    logic        stall_req_mempt2;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    memory_pt2 dut (
        .clk(clk), .rst(rst), .flush(flush), .stall_in(stall_in),
        .req_valid(req_valid), .ld_type(ld_type), .ld_offset(ld_offset),
        .ld_rt_data(ld_rt_data), .ld_wreg(ld_wreg), .data_ok(data_ok),
        .rdata(rdata), .load_busy(load_busy),
        .stall_req_mempt2(stall_req_mempt2), .wb_valid(wb_valid),
        .wb_reg(wb_reg), .wb_data(wb_data)
    );

    // Memory bytes m[0..3] little-endian; register bytes r[0..3].
    function automatic logic [31:0] ref_load(input logic [2:0] t,
        input logic [1:0] off, input logic [31:0] rt, input logic [31:0] rd);
        logic [7:0] m [4];
        logic [7:0] r [4];
        logic [7:0] o [4];
        int k;
        int h;
        for (int i = 0; i < 4; i++) begin
            m[i] = rd[8*i +: 8];
            r[i] = rt[8*i +: 8];
            o[i] = r[i];
        end
        k = int'(off);
        h = off[1] ? 2 : 0;
        case (t)
            3'd0: return {{24{m[k][7]}}, m[k]};
            3'd1: return {24'd0, m[k]};
            3'd2: return {{16{m[h+1][7]}}, m[h+1], m[h]};
            3'd3: return {16'd0, m[h+1], m[h]};
            3'd5: begin
                for (int i = 0; i < 4; i++)
                    if (i >= 3 - k) o[i] = m[i - (3 - k)];
                return {o[3], o[2], o[1], o[0]};
            end
            3'd6: begin
                for (int i = 0; i < 4; i++)
                    if (i <= 3 - k) o[i] = m[i + k];
                return {o[3], o[2], o[1], o[0]};
            end
            default: return rd;
        endcase
    endfunction

    task automatic idle_inputs();
        flush = 0; stall_in = 0; req_valid = 0; data_ok = 0;
        ld_type = 0; ld_offset = 0; ld_rt_data = 0; ld_wreg = 0;
        rdata = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if ({wb_valid, load_busy, stall_req_mempt2} !== 3'b000) begin
            $display("FAIL reset_ctl got %b want 000",
                     {wb_valid, load_busy, stall_req_mempt2});
            n_err++;
        end
        n_cmp++;
        if (wb_data !== 32'd0 || wb_reg !== 5'd0) begin
            $display("FAIL reset_wb got %h/%0d want 0/0", wb_data, wb_reg);
            n_err++;
        end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_directed();
        logic [2:0]  tt [4] = '{3'd0, 3'd1, 3'd5, 3'd6};
        logic [1:0]  to [4] = '{2'd3, 2'd3, 2'd1, 2'd2};
        logic [31:0] tr [4] = '{32'h1234_5678, 32'h1234_5678,
                                32'hAABB_CCDD, 32'hAABB_CCDD};
        logic [31:0] td [4] = '{32'h80FF_0000, 32'h80FF_0000,
                                32'h1122_3344, 32'h1122_3344};
        logic [31:0] te [4] = '{32'hFFFF_FF80, 32'h0000_0080,
                                32'h3344_CCDD, 32'hAABB_1122};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req_valid = 1; ld_type = tt[i]; ld_offset = to[i];
            ld_rt_data = tr[i]; ld_wreg = 5'(i + 3);
            @(negedge clk);
            req_valid = 0; data_ok = 1; rdata = td[i];
            #1;
            n_cmp++;
            if (wb_valid !== 1'b0) begin
                $display("FAIL dir_early_valid[%0d] got %b want 0", i, wb_valid);
                n_err++;
            end
            @(negedge clk);
            data_ok = 0; rdata = 32'h0;
            #1;
            n_cmp++;
            if (wb_valid !== 1'b1 || wb_data !== te[i] ||
                wb_reg !== 5'(i + 3)) begin
                $display("FAIL dir_wb[%0d] got %b/%h/%0d want 1/%h/%0d",
                         i, wb_valid, wb_data, wb_reg, te[i], i + 3);
                n_err++;
            end
            @(negedge clk);
            #1;
            n_cmp++;
            if (wb_valid !== 1'b0 || load_busy !== 1'b0) begin
                $display("FAIL dir_consume[%0d] got %b%b want 00",
                         i, wb_valid, load_busy);
                n_err++;
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  t;
        logic [1:0]  o;
        logic [31:0] rt;
        logic [31:0] rd;
        logic [4:0]  w;
        logic [31:0] exp;
        int dly;
        int stl;
        for (int i = 0; i < 40; i++) begin
            t = 3'($urandom_range(0, 7));
            o = 2'($urandom);
            rt = $urandom;
            rd = $urandom;
            w = 5'($urandom);
            dly = $urandom_range(0, 3);
            stl = $urandom_range(0, 2);
            exp = ref_load(t, o, rt, rd);
            @(negedge clk);
            req_valid = 1; ld_type = t; ld_offset = o;
            ld_rt_data = rt; ld_wreg = w;
            @(negedge clk);
            req_valid = 0; ld_rt_data = $urandom;
            for (int d = 0; d < dly; d++) begin
                #1;
                n_cmp++;
                if (stall_req_mempt2 !== 1'b1 || wb_valid !== 1'b0) begin
                    $display("FAIL rnd_wait[%0d] got %b%b want 10",
                             i, stall_req_mempt2, wb_valid);
                    n_err++;
                end
                @(negedge clk);
            end
            data_ok = 1; rdata = rd;
            @(negedge clk);
            data_ok = 0; rdata = $urandom;
            stall_in = (stl > 0);
            #1;
            n_cmp++;
            if (wb_valid !== 1'b1 || wb_data !== exp || wb_reg !== w ||
                stall_req_mempt2 !== 1'b0) begin
                $display("FAIL rnd_wb[%0d] t=%0d o=%0d got %b/%h/%0d want 1/%h/%0d",
                         i, t, o, wb_valid, wb_data, wb_reg, exp, w);
                n_err++;
            end
            for (int s = 0; s < stl; s++) begin
                @(negedge clk);
                #1;
                n_cmp++;
                if (wb_valid !== 1'b1 || wb_data !== exp ||
                    load_busy !== 1'b1) begin
                    $display("FAIL rnd_hold[%0d] got %b/%h/%b want 1/%h/1",
                             i, wb_valid, wb_data, load_busy, exp);
                    n_err++;
                end
                if (s == stl - 1) stall_in = 0;
            end
            @(negedge clk);
            #1;
            n_cmp++;
            if (wb_valid !== 1'b0 || load_busy !== 1'b0) begin
                $display("FAIL rnd_drain[%0d] got %b%b want 00",
                         i, wb_valid, load_busy);
                n_err++;
            end
        end
    endtask

    task automatic test_delay3();
        @(negedge clk);
        req_valid = 1; ld_type = 3'd4; ld_offset = 0; ld_wreg = 5'd12;
        @(negedge clk);
        req_valid = 0;
        for (int d = 0; d < 3; d++) begin
            #1;
            n_cmp++;
            if (stall_req_mempt2 !== 1'b1) begin
                $display("FAIL dly3_stall[%0d] got %b want 1", d, stall_req_mempt2);
                n_err++;
            end
            @(negedge clk);
        end
        data_ok = 1; rdata = 32'hCAFE_F00D;
        @(negedge clk);
        data_ok = 0;
        #1;
        n_cmp++;
        if (stall_req_mempt2 !== 1'b0 || wb_valid !== 1'b1 ||
            wb_data !== 32'hCAFE_F00D) begin
            $display("FAIL dly3_done got %b/%b/%h want 0/1/cafef00d",
                     stall_req_mempt2, wb_valid, wb_data);
            n_err++;
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        req_valid = 1; ld_type = 3'd4; ld_offset = 0; ld_wreg = 5'd7;
        @(negedge clk);
        req_valid = 0; data_ok = 1; rdata = 32'h0BAD_F00D;
        @(negedge clk);
        data_ok = 0; stall_in = 1; rdata = 32'h5555_5555;
        for (int s = 0; s < 4; s++) begin
            #1;
            n_cmp++;
            if (wb_valid !== 1'b1 || wb_data !== 32'h0BAD_F00D ||
                wb_reg !== 5'd7 || load_busy !== 1'b1) begin
                $display("FAIL b2b_hold[%0d] got %b/%h/%0d/%b want 1/0badf00d/7/1",
                         s, wb_valid, wb_data, wb_reg, load_busy);
                n_err++;
            end
            @(negedge clk);
        end
        stall_in = 0; req_valid = 1;
        ld_type = 3'd1; ld_offset = 2'd2; ld_wreg = 5'd9;
        @(negedge clk);
        req_valid = 0; data_ok = 1; rdata = 32'h00C3_0000;
        #1;
        n_cmp++;
        if (stall_req_mempt2 !== 1'b1 || wb_valid !== 1'b0) begin
            $display("FAIL b2b_wait got %b%b want 10", stall_req_mempt2, wb_valid);
            n_err++;
        end
        @(negedge clk);
        data_ok = 0;
        #1;
        n_cmp++;
        if (wb_valid !== 1'b1 || wb_data !== 32'h0000_00C3 || wb_reg !== 5'd9) begin
            $display("FAIL b2b_wb got %b/%h/%0d want 1/000000c3/9",
                     wb_valid, wb_data, wb_reg);
            n_err++;
        end
        @(negedge clk);
    endtask

    task automatic test_flush();
        // flush in WAIT without data -> DROP
        @(negedge clk);
        req_valid = 1; ld_type = 3'd4; ld_wreg = 5'd20;
        @(negedge clk);
        req_valid = 0; flush = 1;
        #1;
        n_cmp++;
        if (stall_req_mempt2 !== 1'b0) begin
            $display("FAIL fl_mask got %b want 0", stall_req_mempt2);
            n_err++;
        end
        @(negedge clk);
        flush = 0; req_valid = 1;
        #1;
        n_cmp++;
        if (load_busy !== 1'b1 || wb_valid !== 1'b0) begin
            $display("FAIL fl_drop got %b%b want 10", load_busy, wb_valid);
            n_err++;
        end
        @(negedge clk);
        req_valid = 0; data_ok = 1; rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        data_ok = 0;
        #1;
        n_cmp++;
        if (wb_valid !== 1'b0 || load_busy !== 1'b0) begin
            $display("FAIL fl_discard got %b%b want 00", wb_valid, load_busy);
            n_err++;
        end
        // flush together with data_ok in WAIT
        @(negedge clk);
        req_valid = 1;
        @(negedge clk);
        req_valid = 0; flush = 1; data_ok = 1;
        @(negedge clk);
        flush = 0; data_ok = 0;
        #1;
        n_cmp++;
        if (wb_valid !== 1'b0 || load_busy !== 1'b0) begin
            $display("FAIL fl_dataok got %b%b want 00", wb_valid, load_busy);
            n_err++;
        end
        // flush in DONE kills the result; data_ok in IDLE is ignored
        @(negedge clk);
        req_valid = 1;
        @(negedge clk);
        req_valid = 0; data_ok = 1;
        @(negedge clk);
        data_ok = 0; flush = 1; stall_in = 1;
        @(negedge clk);
        flush = 0; stall_in = 0; data_ok = 1;
        #1;
        n_cmp++;
        if (wb_valid !== 1'b0 || load_busy !== 1'b0) begin
            $display("FAIL fl_done got %b%b want 00", wb_valid, load_busy);
            n_err++;
        end
        @(negedge clk);
        data_ok = 0;
        #1;
        n_cmp++;
        if (wb_valid !== 1'b0) begin
            $display("FAIL idle_dataok got %b want 0", wb_valid);
            n_err++;
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_valid = 1; ld_type = 3'd4; ld_wreg = 5'd31;
        @(negedge clk);
        req_valid = 0;
        #2 rst = 1;
        #1;
        n_cmp++;
        if ({wb_valid, load_busy, stall_req_mempt2} !== 3'b000 ||
            wb_data !== 32'd0 || wb_reg !== 5'd0) begin
            $display("FAIL rst_mid got %b/%h/%0d want 000/0/0",
                     {wb_valid, load_busy, stall_req_mempt2}, wb_data, wb_reg);
            n_err++;
        end
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        data_ok = 1; rdata = 32'h1357_9BDF;
        @(negedge clk);
        data_ok = 0;
        #1;
        n_cmp++;
        if (wb_valid !== 1'b0 || wb_data !== 32'd0) begin
            $display("FAIL rst_late got %b/%h want 0/0", wb_valid, wb_data);
            n_err++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_delay3();
        test_back_to_back();
        test_random();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
